// File: rtl/m_div_ctrl.sv
// m_div_ctrl: issue/sequencing controller in front of an iterative RV32M divider core.
//
// Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake, answers divide-by-zero,
// signed overflow and repeat-operand hits from a one-entry result cache in one cycle, and
// otherwise starts the core and waits for it, guarded by a watchdog. Flush kills the
// in-flight op. If the core is already running, the controller drains it first.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   i_reqValid_1/o_reqReady_1   request handshake (ready only in IDLE)
//   i_reqOp_2                   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_reqA_32/i_reqB_32         dividend / divisor
//   o_respValid_1/i_respReady_1 response handshake
//   o_respData_32, o_respErr_1  quotient or remainder; err flags a watchdog abort (data 0)
//   i_flush_1                   kill in-flight op
//   o_busy_1                    controller not idle
//   o_divBegin_1                one-cycle core start pulse
//   o_mulDivSign_2              {1'b0, signed} to core
//   o_divOperand1_32/2_32       operands to core, held stable while it runs
//   i_divEnd_1                  core done; i_quotient_32/i_remainder_32 valid in that cycle
module m_div_ctrl #(
  parameter bit          CACHE_EN    = 1'b1,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_reqValid_1,
  output logic        o_reqReady_1,
  input  logic [1:0]  i_reqOp_2,
  input  logic [31:0] i_reqA_32,
  input  logic [31:0] i_reqB_32,
  output logic        o_respValid_1,
  input  logic        i_respReady_1,
  output logic [31:0] o_respData_32,
  output logic        o_respErr_1,
  input  logic        i_flush_1,
  output logic        o_busy_1,
  output logic        o_divBegin_1,
  output logic [1:0]  o_mulDivSign_2,
  output logic [31:0] o_divOperand1_32,
  output logic [31:0] o_divOperand2_32,
  input  logic        i_divEnd_1,
  input  logic [31:0] i_quotient_32,
  input  logic [31:0] i_remainder_32
);

  // Counter value at which the cycle being spent in WAIT/DRAIN is the last one allowed.
  localparam logic [7:0] WdogLast = 8'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

  state_e state_q, state_d;

  logic        sign_q, rem_q;
  logic [31:0] a_q, b_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic [7:0]  wdog_q;

  logic        cache_valid_q, cache_sign_q;
  logic [31:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;

  logic        accept, req_signed, div_zero, sgn_ovf, cache_hit, fast_path, wdog_expire;
  logic [31:0] fast_quo, fast_rem, fast_data;

  assign accept      = i_reqValid_1 && (state_q == StIdle);
  assign req_signed  = ~i_reqOp_2[0];
  assign div_zero    = (i_reqB_32 == 32'h0);
  assign sgn_ovf     = req_signed && (i_reqA_32 == 32'h8000_0000) && (i_reqB_32 == 32'hFFFF_FFFF);
  assign cache_hit   = CACHE_EN && cache_valid_q && (i_reqA_32 == cache_a_q) &&
                       (i_reqB_32 == cache_b_q) && (req_signed == cache_sign_q);
  assign fast_path   = div_zero || sgn_ovf || cache_hit;
  // >= so that a flush landing on the last WAIT cycle still expires in DRAIN.
  assign wdog_expire = (wdog_q >= WdogLast);

  // Special cases override the cache.
  always_comb begin
    fast_quo = cache_quo_q;
    fast_rem = cache_rem_q;
    if (div_zero) begin
      fast_quo = 32'hFFFF_FFFF;
      fast_rem = i_reqA_32;
    end else if (sgn_ovf) begin
      fast_quo = 32'h8000_0000;
      fast_rem = 32'h0;
    end
  end

  assign fast_data = i_reqOp_2[1] ? fast_rem : fast_quo;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush outranks every other event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_flush_1) begin
          state_d = StIdle;
        end else if (accept) begin
          state_d = fast_path ? StResp : StIssue;
        end
      end
      // The begin pulse is already out, so a flush here must drain the core.
      StIssue: state_d = i_flush_1 ? StDrain : StWait;
      StWait: begin
        if (i_flush_1) begin
          state_d = i_divEnd_1 ? StIdle : StDrain;
        end else if (i_divEnd_1 || wdog_expire) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (i_flush_1 || i_respReady_1) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (i_divEnd_1 || wdog_expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request, response, watchdog and cache registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q        <= 1'b0;
      rem_q         <= 1'b0;
      a_q           <= 32'h0;
      b_q           <= 32'h0;
      resp_data_q   <= 32'h0;
      resp_err_q    <= 1'b0;
      wdog_q        <= 8'h0;
      cache_valid_q <= 1'b0;
      cache_sign_q  <= 1'b0;
      cache_a_q     <= 32'h0;
      cache_b_q     <= 32'h0;
      cache_quo_q   <= 32'h0;
      cache_rem_q   <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept && !i_flush_1) begin
            sign_q      <= req_signed;
            rem_q       <= i_reqOp_2[1];
            a_q         <= i_reqA_32;
            b_q         <= i_reqB_32;
            resp_data_q <= fast_data;
            resp_err_q  <= 1'b0;
          end
        end
        StIssue: wdog_q <= 8'h0;
        StWait: begin
          if (!wdog_expire) begin
            wdog_q <= wdog_q + 8'd1;
          end
          if (!i_flush_1) begin
            if (i_divEnd_1) begin
              resp_data_q   <= rem_q ? i_remainder_32 : i_quotient_32;
              resp_err_q    <= 1'b0;
              cache_valid_q <= 1'b1;
              cache_sign_q  <= sign_q;
              cache_a_q     <= a_q;
              cache_b_q     <= b_q;
              cache_quo_q   <= i_quotient_32;
              cache_rem_q   <= i_remainder_32;
            end else if (wdog_expire) begin
              resp_data_q   <= 32'h0;
              resp_err_q    <= 1'b1;
              cache_valid_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (!wdog_expire) begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    o_reqReady_1  = 1'b0;
    o_busy_1      = 1'b1;
    o_divBegin_1  = 1'b0;
    o_respValid_1 = 1'b0;
    o_respData_32 = 32'h0;
    o_respErr_1   = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_reqReady_1 = 1'b1;
        o_busy_1     = 1'b0;
      end
      StIssue: o_divBegin_1 = 1'b1;
      StResp: begin
        o_respValid_1 = 1'b1;
        o_respData_32 = resp_data_q;
        o_respErr_1   = resp_err_q;
      end
      default: ;
    endcase
  end

  assign o_mulDivSign_2   = {1'b0, sign_q};
  assign o_divOperand1_32 = a_q;
  assign o_divOperand2_32 = b_q;

endmodule
